clock_seg_scan: RTL and testbench
=================================

// Module: clock_seg_scan
// PURPOSE
//  Multiplexed 6-digit seven-segment driver for the LED clock. Sits downstream of the
//  time counters: takes the BCD sec/min/hr digits and produces per-digit segment and
//  digit-select drive. Frame-consistent snapshot, anti-ghost blanking, blink of the
//  field being set, blinking separator points.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (50 MHz -> 1 kHz slot rate)
//  BLANK_CYC  500    cycles at slot start with all digits off; legal 0..SCAN_DIV-1
//  BLINK_DIV  250    slot ticks per blink phase toggle
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  upd        in   1  1-cycle strobe: digit inputs are valid and new
//  sec_lo     in   4  BCD seconds units
//  sec_hi     in   4  BCD seconds tens
//  min_lo     in   4  BCD minutes units
//  min_hi     in   4  BCD minutes tens
//  hr_lo      in   4  BCD hours units
//  hr_hi      in   4  BCD hours tens
//  blink_sel  in   2  0 none, 1 seconds pair, 2 minutes pair, 3 hours pair
//  seg        out  8  active-low {dp,g,f,e,d,c,b,a}
//  dig        out  6  active-low digit enables; dig[0]=sec_lo .. dig[5]=hr_hi
// BEHAVIOUR
//  - Reset (rst=0, async): seg=8'hFF, dig=6'h3F, prescaler/idx/blank/blink counters 0,
//    pending and display registers 0, pend_vld=0, phase=0.
//  - Prescaler pre counts 0..SCAN_DIV-1 and wraps; slot_tick when pre==SCAN_DIV-1.
//  - Digit index idx 0..5 advances on slot_tick; 5 wraps to 0 (frame boundary).
//  - Snapshot: upd=1 loads all six inputs into pending regs, sets pend_vld.
//    At frame boundary (slot_tick with idx==5) pending -> display regs if pend_vld,
//    clears pend_vld. upd on the boundary cycle: inputs go straight to display, pend_vld=0.
//    Display regs never change mid-frame.
//  - Decode: 0..9 standard; 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (dp off).
//    Values 10..15 show dash: g only (8'hBF).
//  - Separators: dp lit (seg[7]=0) on idx 2 and idx 4 when phase==0, off when phase==1.
//  - Blink: phase toggles every BLINK_DIV slot_ticks (counter wraps at BLINK_DIV-1).
//    phase==1: digits of selected pair have dig bit held 1 (off) for whole slot.
//    blink_sel sampled every cycle; change takes effect next cycle.
//  - Blanking: while pre < BLANK_CYC, dig=6'h3F. Otherwise exactly one dig bit low (=idx),
//    unless blinked off.
//  - Latency: seg/dig registered; reflect pre/idx/phase state of previous cycle (1 clk).
//  - rst mid-frame: outputs off immediately, scan restarts at idx 0, display shows 00:00:00.
// TESTING  (SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=3)
//  - Reset release, no upd -> dig cycles 3E,3D,3B,37,2F,1F, each low 3 clk after 1 clk 3F;
//    seg=C0 on every digit; dp low on idx 2,4.
//  - upd with 12:34:56 mid-frame -> unchanged until next idx 0 slot, then sec_lo seg=82,
//    sec_hi 92, min_lo 99, min_hi B0, hr_lo A4, hr_hi F9 (dp as per phase).
//  - upd held exactly on the idx==5 slot_tick cycle -> new value shown from idx 0 of
//    the immediately following frame; second upd mid-frame defers to next boundary.
//  - blink_sel=2 -> after 3 slot_ticks phase=1: dig[2],dig[3] never low, dp off on idx 2,4;
//    after 3 more, normal; blink_sel=0 -> never blanked.
//  - sec_lo=4'hC, hr_hi=4'hF -> seg=BF on those digits.
//  - Assert rst during idx 3 -> same cycle seg=FF, dig=3F; after release scan resumes at
//    idx 0 showing 00:00:00 until next upd+boundary.

Source files
------------

// File: rtl/clock_seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_seg_scan_if
//  Description : Digit/blink inputs and segment/digit drive outputs of the
//                multiplexed six-digit seven-segment clock display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_seg_scan_if;
  logic       i_upd;
  logic [3:0] i_sec_lo;
  logic [3:0] i_sec_hi;
  logic [3:0] i_min_lo;
  logic [3:0] i_min_hi;
  logic [3:0] i_hr_lo;
  logic [3:0] i_hr_hi;
  logic [1:0] i_blink_sel;
  logic [7:0] o_seg;
  logic [5:0] o_dig;

  // Time source side: drives digits, observes the display drive
  modport master (
    output i_upd, i_sec_lo, i_sec_hi, i_min_lo, i_min_hi, i_hr_lo, i_hr_hi,
    output i_blink_sel,
    input  o_seg, o_dig
  );

  // Display driver side
  modport slave (
    input  i_upd, i_sec_lo, i_sec_hi, i_min_lo, i_min_hi, i_hr_lo, i_hr_hi,
    input  i_blink_sel,
    output o_seg, o_dig
  );
endinterface
`default_nettype wire

// File: rtl/clock_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : clock_seg_scan
//  Description : Multiplexed 6-digit seven-segment driver. Frame-consistent
//                snapshot of BCD time digits, anti-ghost blanking at the
//                start of each digit slot, blink of the selected field pair
//                and blinking separator points. Active-low outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 250
) (
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active-low
  clock_seg_scan_if.slave   bus
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] c_pre_last   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] c_blank      = PW'(BLANK_CYC);
  localparam logic [BW-1:0] c_blink_last = BW'(BLINK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [23:0]   r_pend;      // {hr_hi,hr_lo,min_hi,min_lo,sec_hi,sec_lo}
  logic          r_pend_vld;
  logic [23:0]   r_disp;
  logic [7:0]    r_seg;
  logic [5:0]    r_dig;

  logic          w_slot_tick;
  logic          w_frame_end;
  logic [23:0]   w_in;
  logic [3:0]    w_cur;
  logic          w_blanked;
  logic          w_blink_off;
  logic          w_dp_on;
  logic [7:0]    w_seg_nxt;
  logic [5:0]    w_dig_nxt;

  assign w_slot_tick = (r_pre == c_pre_last);
  assign w_frame_end = w_slot_tick && (r_idx == 3'd5);
  assign w_in        = {bus.i_hr_hi, bus.i_hr_lo, bus.i_min_hi,
                        bus.i_min_lo, bus.i_sec_hi, bus.i_sec_lo};

  // BCD to active-low {g..a}; non-BCD codes show a dash
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  // Slot prescaler and digit index; idx wrap marks the frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= 3'd0;
    end else if (w_slot_tick) begin
      r_pre <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Blink phase toggles every BLINK_DIV slot ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_slot_tick) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Snapshot: updates park in pending and only reach the display at a frame
  // boundary, so a frame never mixes old and new digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_disp     <= '0;
    end else if (w_frame_end) begin
      if (bus.i_upd)       r_disp <= w_in;
      else if (r_pend_vld) r_disp <= r_pend;
      r_pend_vld <= 1'b0;
    end else if (bus.i_upd) begin
      r_pend     <= w_in;
      r_pend_vld <= 1'b1;
    end
  end

  // Select the displayed digit for the current slot
  always_comb begin
    w_cur = r_disp[3:0];
    case (r_idx)
      3'd1:    w_cur = r_disp[7:4];
      3'd2:    w_cur = r_disp[11:8];
      3'd3:    w_cur = r_disp[15:12];
      3'd4:    w_cur = r_disp[19:16];
      3'd5:    w_cur = r_disp[23:20];
      default: w_cur = r_disp[3:0];
    endcase
  end

  // Next segment/digit drive from the current scan state
  always_comb begin
    w_blanked   = (r_pre < c_blank);
    w_blink_off = r_phase && (bus.i_blink_sel != 2'd0) &&
                  (r_idx[2:1] == (bus.i_blink_sel - 2'd1));
    w_dp_on     = !r_phase && ((r_idx == 3'd2) || (r_idx == 3'd4));
    w_seg_nxt   = {~w_dp_on, f_decode(w_cur)};
    w_dig_nxt   = 6'h3F;
    if (!w_blanked && !w_blink_off)
      w_dig_nxt = ~(6'b000001 << r_idx);
  end

  // Registered display drive; all off while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= 8'hFF;
      r_dig <= 6'h3F;
    end else begin
      r_seg <= w_seg_nxt;
      r_dig <= w_dig_nxt;
    end
  end

  assign bus.o_seg = r_seg;
  assign bus.o_dig = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_clock_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_seg_scan
//  Description : Self-checking bench for clock_seg_scan with a cycle-count
//                based reference model and hand-computed pinned expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_seg_scan;

  localparam int c_scan  = 4;
  localparam int c_blank = 1;
  localparam int c_blink = 3;
  localparam int c_frame = 6 * c_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  clock_seg_scan_if ifc();

  clock_seg_scan #(.SCAN_DIV(c_scan), .BLANK_CYC(c_blank), .BLINK_DIV(c_blink)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Segment table for digit values 0..15
  logic [7:0] c_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  // Reference model: everything derives from the cycle count since reset release
  int         m_t;
  logic [3:0] m_disp [6];
  logic [3:0] m_pend [6];
  bit         m_pv;
  logic [7:0] exp_seg;
  logic [5:0] exp_dig;
  bit         exp_seg_chk;

  always @(posedge clk or negedge rst) begin
    int pre, slot, idx, ph, bsel;
    logic [3:0] in_d [6];
    if (!rst) begin
      m_t = 0;
      m_pv = 1'b0;
      for (int i = 0; i < 6; i++) begin m_disp[i] = 4'd0; m_pend[i] = 4'd0; end
      exp_seg = 8'hFF;
      exp_dig = 6'h3F;
      exp_seg_chk = 1'b1;
    end else begin
      pre  = m_t % c_scan;
      slot = m_t / c_scan;
      idx  = slot % 6;
      ph   = (slot / c_blink) % 2;
      bsel = int'(ifc.i_blink_sel);
      exp_seg = c_tab[m_disp[idx]];
      if (ph == 0 && (idx == 2 || idx == 4)) exp_seg[7] = 1'b0;
      exp_seg_chk = (pre >= c_blank);
      if (pre < c_blank || (ph == 1 && bsel != 0 && idx / 2 == bsel - 1))
        exp_dig = 6'h3F;
      else
        exp_dig = 6'h3F ^ (6'd1 << idx);
      in_d = '{ifc.i_sec_lo, ifc.i_sec_hi, ifc.i_min_lo, ifc.i_min_hi, ifc.i_hr_lo, ifc.i_hr_hi};
      if (m_t % c_frame == c_frame - 1) begin
        if (ifc.i_upd) m_disp = in_d;
        else if (m_pv) m_disp = m_pend;
        m_pv = 1'b0;
      end else if (ifc.i_upd) begin
        m_pend = in_d;
        m_pv = 1'b1;
      end
      m_t++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (ifc.o_dig !== exp_dig) begin
        n_bad++;
        $display("FAIL model_dig t=%0d got=%h exp=%h", m_t, ifc.o_dig, exp_dig);
      end
      if (exp_seg_chk) begin
        n_cmp++;
        if (ifc.o_seg !== exp_seg) begin
          n_bad++;
          $display("FAIL model_seg t=%0d got=%h exp=%h", m_t, ifc.o_seg, exp_seg);
        end
      end
    end
  end

  // Wait (at a falling edge) until the model has consumed n cycles
  task automatic wait_n(input int n);
    int g = 0;
    while (m_t != n && g < 10000) begin @(negedge clk); g++; end
    if (m_t != n) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for cycle %0d (at %0d)", n, m_t);
    end
  endtask

  // Literal check of the outputs produced from scan state s
  task automatic pin(input string nm, input int s, input bit cseg,
                     input logic [7:0] eseg, input logic [5:0] edig);
    wait_n(s + 1);
    n_cmp++;
    if (ifc.o_dig !== edig) begin
      n_bad++;
      $display("FAIL %s dig got=%h exp=%h", nm, ifc.o_dig, edig);
    end
    if (cseg) begin
      n_cmp++;
      if (ifc.o_seg !== eseg) begin
        n_bad++;
        $display("FAIL %s seg got=%h exp=%h", nm, ifc.o_seg, eseg);
      end
    end
  endtask

  task automatic set_digits(input logic [3:0] hh, hl, mh, ml, sh, sl);
    ifc.i_hr_hi = hh; ifc.i_hr_lo = hl; ifc.i_min_hi = mh;
    ifc.i_min_lo = ml; ifc.i_sec_hi = sh; ifc.i_sec_lo = sl;
  endtask

  // One-cycle update strobe during scan state s
  task automatic upd_at(input int s, input logic [3:0] hh, hl, mh, ml, sh, sl);
    wait_n(s);
    set_digits(hh, hl, mh, ml, sh, sl);
    ifc.i_upd = 1'b1;
    @(negedge clk);
    ifc.i_upd = 1'b0;
  endtask

  initial begin
    ifc.i_upd = 1'b0;
    ifc.i_blink_sel = 2'd0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    pin("reset", -1, 1'b1, 8'hFF, 6'h3F);
    @(negedge clk);
    rst = 1'b1;

    // Free-running scan of 00:00:00
    pin("blank0", 0, 1'b0, 8'hFF, 6'h3F);
    pin("idx0",   1, 1'b1, 8'hC0, 6'h3E);
    pin("idx2dp", 9, 1'b1, 8'h40, 6'h3B);
    pin("idx4ph1", 17, 1'b1, 8'hC0, 6'h2F);
    pin("idx5",   21, 1'b1, 8'hC0, 6'h1F);

    // Mid-frame update shows only from the next frame
    upd_at(30, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    pin("held",   45, 1'b1, 8'hC0, 6'h1F);
    pin("sec_lo", 49, 1'b1, 8'h82, 6'h3E);
    pin("sec_hi", 53, 1'b1, 8'h92, 6'h3D);
    pin("min_lo", 57, 1'b1, 8'h19, 6'h3B);
    pin("min_hi", 61, 1'b1, 8'hB0, 6'h37);
    pin("hr_lo",  65, 1'b1, 8'hA4, 6'h2F);
    pin("hr_hi",  69, 1'b1, 8'hF9, 6'h1F);

    // Update on the boundary cycle, then a deferred mid-frame update
    upd_at(95, 4'd0, 4'd7, 4'd0, 4'd8, 4'd0, 4'd9);
    pin("bnd_upd", 97, 1'b1, 8'h90, 6'h3E);
    upd_at(100, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    pin("defer_old", 117, 1'b1, 8'hC0, 6'h1F);
    pin("defer_new", 121, 1'b1, 8'hF9, 6'h3E);

    // Blink minutes pair
    wait_n(125);
    ifc.i_blink_sel = 2'd2;
    pin("blink_off", 133, 1'b1, 8'hF9, 6'h3F);

    // Non-BCD codes
    upd_at(140, 4'hF, 4'd0, 4'd0, 4'd0, 4'd0, 4'hC);
    pin("dash_lo", 145, 1'b1, 8'hBF, 6'h3E);
    pin("dash_hi", 165, 1'b1, 8'hBF, 6'h1F);

    // Randomized traffic checked against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      ifc.i_upd = ($urandom_range(0, 7) == 0);
      if (ifc.i_upd)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 40) == 0) ifc.i_blink_sel = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    ifc.i_upd = 1'b0;
    ifc.i_blink_sel = 2'd0;

    // Asynchronous reset while scanning idx 3
    begin
      int g = 0;
      while (((m_t / c_scan) % 6) != 3 && g < 100) begin @(negedge clk); g++; end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ifc.o_seg !== 8'hFF || ifc.o_dig !== 6'h3F) begin
      n_bad++;
      $display("FAIL async_rst got=%h/%h exp=ff/3f", ifc.o_seg, ifc.o_dig);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pin("rst_idx0", 1,  1'b1, 8'hC0, 6'h3E);
    pin("rst_idx5", 22, 1'b1, 8'hC0, 6'h1F);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
